// File: rtl/key_auto_repeat.sv
//------------------------------------------------------------------------------
// Module   : key_auto_repeat
// Purpose  : Turns debounced up/down key levels into one-cycle step pulses:
//            a press pulse, then after a hold delay a periodic repeat train.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module key_auto_repeat #(
    parameter int CNT_W         = 24,
    parameter int HOLD_DELAY    = 12_000_000,
    parameter int REPEAT_PERIOD = 3_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_up,
    input  logic key_down,
    output logic up_step,
    output logic down_step,
    output logic repeating
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             active_up;
    logic             act_held;
    logic             other_held;

    // Key that started the hold, and the opposing key that forces a lockout.
    assign act_held   = active_up ? key_up   : key_down;
    assign other_held = active_up ? key_down : key_up;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            active_up <= 1'b0;
            up_step   <= 1'b0;
            down_step <= 1'b0;
            repeating <= 1'b0;
        end else begin
            up_step   <= 1'b0;
            down_step <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    repeating <= 1'b0;
                    if (key_up ^ key_down) begin
                        state     <= HOLD;
                        active_up <= key_up;
                        up_step   <= key_up;
                        down_step <= key_down;
                    end else if (key_up && key_down) begin
                        state <= LOCK;
                    end
                end
                HOLD, REPEAT: begin
                    // Release wins over lockout, and both suppress a due pulse.
                    if (!act_held) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        repeating <= 1'b0;
                    end else if (other_held) begin
                        state     <= LOCK;
                        cnt       <= '0;
                        repeating <= 1'b0;
                    end else if (cnt == ((state == HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                        state     <= REPEAT;
                        cnt       <= '0;
                        repeating <= 1'b1;
                        up_step   <= active_up;
                        down_step <= !active_up;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOCK: begin
                    cnt       <= '0;
                    repeating <= 1'b0;
                    if (!key_up && !key_down) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    repeating <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_key_auto_repeat.sv
//------------------------------------------------------------------------------
// Module   : tb_key_auto_repeat
// Purpose  : Self-checking bench for key_auto_repeat against a press-age model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_key_auto_repeat;

    localparam int HD = 8;
    localparam int RP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic key_up = 1'b0;
    logic key_down = 1'b0;
    logic up_step, down_step, repeating;

    int n_chk  = 0;
    int n_fail = 0;
    int n_up   = 0;
    int n_dn   = 0;

    // Reference model: where the key is in its life, measured as press age.
    typedef enum int {M_IDLE, M_HELD, M_LOCK} mode_t;
    mode_t mode    = M_IDLE;
    logic  held_up = 1'b0;
    int    age     = 0;
    logic  exp_up  = 1'b0;
    logic  exp_dn  = 1'b0;
    logic  exp_rep = 1'b0;

    key_auto_repeat #(
        .CNT_W        (8),
        .HOLD_DELAY   (HD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_up   (key_up),
        .key_down (key_down),
        .up_step  (up_step),
        .down_step(down_step),
        .repeating(repeating)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs after a rising edge that sampled keys (u, d).
    task automatic model_edge(input logic u, input logic d);
        logic act, oth, pulse;
        pulse = 1'b0;
        case (mode)
            M_IDLE: begin
                if (u ^ d) begin
                    mode    = M_HELD;
                    held_up = u;
                    age     = 0;
                    pulse   = 1'b1;
                end else if (u && d) begin
                    mode = M_LOCK;
                end
            end
            M_HELD: begin
                act = held_up ? u : d;
                oth = held_up ? d : u;
                if (!act) begin
                    mode = M_IDLE;
                end else if (oth) begin
                    mode = M_LOCK;
                end else begin
                    age++;
                    pulse = (age == HD) || (age > HD && ((age - HD) % RP) == 0);
                end
            end
            default: begin
                if (!u && !d) mode = M_IDLE;
            end
        endcase
        exp_up  = pulse && held_up;
        exp_dn  = pulse && !held_up;
        exp_rep = (mode == M_HELD) && (age >= HD);
    endtask

    task automatic model_reset();
        mode    = M_IDLE;
        age     = 0;
        exp_up  = 1'b0;
        exp_dn  = 1'b0;
        exp_rep = 1'b0;
    endtask

    // One clock: drive at the falling edge, compare at the next falling edge.
    task automatic cyc(input logic u, input logic d);
        key_up   = u;
        key_down = d;
        @(posedge clk);
        model_edge(u, d);
        @(negedge clk);
        check("up_step", up_step, exp_up);
        check("down_step", down_step, exp_dn);
        check("repeating", repeating, exp_rep);
        if (up_step) n_up++;
        if (down_step) n_dn++;
    endtask

    task automatic cycn(input logic u, input logic d, input int n);
        for (int i = 0; i < n; i++) cyc(u, d);
    endtask

    // Asynchronous reset pulse in mid-cycle; keys keep their current levels.
    task automatic reset_mid();
        #2 rst = 1'b0;
        #1;
        check("rst_up_step", up_step, 0);
        check("rst_down_step", down_step, 0);
        check("rst_repeating", repeating, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int sel, len;
        @(negedge clk);
        check("reset_up_step", up_step, 0);
        check("reset_down_step", down_step, 0);
        check("reset_repeating", repeating, 0);
        @(negedge clk);
        rst = 1'b1;
        cycn(0, 0, 3);

        // Short press: a single press pulse only.
        n_up = 0; n_dn = 0;
        cycn(1, 0, 3);
        cycn(0, 0, 5);
        check("short_press_up_pulses", n_up, 1);
        check("short_press_down_pulses", n_dn, 0);

        // Long hold: press pulse plus repeats at +8, +12, +16.
        n_up = 0; n_dn = 0;
        cycn(0, 1, 20);
        check("hold20_down_pulses", n_dn, 4);
        cycn(0, 0, 2);

        // Opposite key during repeat locks out until both released.
        cycn(1, 0, 14);
        n_up = 0; n_dn = 0;
        cycn(1, 1, 5);
        cycn(1, 0, 4);
        check("lock_no_pulses", n_up + n_dn, 0);
        cycn(0, 0, 1);
        n_up = 0;
        cycn(1, 0, 1);
        check("after_lock_repress", n_up, 1);
        cycn(0, 0, 2);

        // Simultaneous press from idle goes straight to lockout.
        n_up = 0; n_dn = 0;
        cycn(1, 1, 4);
        cycn(0, 1, 3);
        check("both_press_no_pulses", n_up + n_dn, 0);
        cycn(0, 0, 1);

        // Release exactly where the first repeat would fire.
        n_up = 0;
        cycn(1, 0, HD);
        cycn(0, 0, 1);
        check("release_at_repeat_pulses", n_up, 1);
        cycn(1, 0, 1);
        check("repress_after_release", n_up, 2);
        cycn(0, 0, 1);

        // Back-to-back presses with a single low cycle.
        n_dn = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1);
            cyc(0, 0);
        end
        check("back_to_back_pulses", n_dn, 3);

        // Reset while repeating with the key still held.
        cycn(1, 0, 14);
        reset_mid();
        n_up = 0;
        cyc(1, 0);
        check("press_after_reset", n_up, 1);
        cycn(0, 0, 2);

        // Randomized key segments with occasional resets.
        for (int s = 0; s < 160; s++) begin
            sel = $urandom_range(0, 19);
            len = $urandom_range(1, 24);
            if (sel < 7)       cycn(1, 0, len);
            else if (sel < 13) cycn(0, 1, len);
            else if (sel < 15) cycn(1, 1, len);
            else if (sel < 19) cycn(0, 0, (sel == 18) ? 1 : len);
            else               reset_mid();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
